cr_coretim_mch: RTL and testbench

- Multi-channel, parametrised core timer for the e902 core complex; next generation of the single-channel SysTick-style timer.
- Provides CH_NUM independent down-counters of CNT_WIDTH bits, each with:
  - periodic or one-shot mode;
  - a per-channel prescaler;
  - CPU-clock or synchronised reference-clock tick source;
  - its own interrupt.
- Sits behind the TCIPIF register slave and drives per-channel interrupt lines to the interrupt controller.

---
 rtl/cr_coretim_mch.sv | 195 +++++++++++++++++++
 tb/tb_cr_coretim_mch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cr_coretim_mch.sv
// cr_coretim_mch: multi-channel core timer for the e902 core complex.
// Each of CH_NUM channels is a CNT_WIDTH-bit reload down-counter with its own
// prescaler, tick source (cpuclk or synchronised reference clock), periodic or
// one-shot mode and interrupt line, all programmed through the TCIPIF slave.
// Optional build macro: CR_CORETIM_CASCADE_EN adds CSR bit 4 (casc), which lets
// channel n>0 count on the delayed reach-zero pulse of channel n-1.
module cr_coretim_mch #(
  parameter int CNT_WIDTH = 24,
  parameter int CH_NUM    = 2,
  parameter int PSC_WIDTH = 8
) (
  input  logic              ct_reg_cpuclk,
  input  logic              coretim_rst_b,
  input  logic              core_dbgon,
  input  logic              pad_ctim_refclk,
  input  logic [25:0]       pad_ctim_calib,
  input  logic              tcipif_coretim_sel,
  input  logic              tcipif_coretim_write,
  input  logic [15:0]       tcipif_coretim_addr,
  input  logic [31:0]       tcipif_coretim_wdata,
  output logic              coretim_tcipif_cmplt,
  output logic [31:0]       coretim_tcipif_rdata,
  output logic [CH_NUM-1:0] ctim_pad_int_vld,
  output logic              ctim_pad_int_any
);

  logic [2:0]           ref_sync;
  logic                 ref_tick;
  logic                 noref;
  logic                 rd_en;
  logic                 wr_en;
  logic [3:0]           addr_ch;
  logic [1:0]           addr_reg;
  logic [31:0]          calib_word;
  logic [31:0]          csr_word [CH_NUM];
  logic [CNT_WIDTH-1:0] rvr_word [CH_NUM];
  logic [CNT_WIDTH-1:0] cnt_word [CH_NUM];
  logic                 unused_bits;
`ifdef CR_CORETIM_CASCADE_EN
  logic [CH_NUM-1:0]    rz_q_vec;
`endif

  assign noref       = pad_ctim_calib[25];
  assign rd_en       = tcipif_coretim_sel & ~tcipif_coretim_write;
  assign wr_en       = tcipif_coretim_sel & tcipif_coretim_write;
  assign addr_ch     = tcipif_coretim_addr[7:4];
  assign addr_reg    = tcipif_coretim_addr[3:2];
  assign calib_word  = {pad_ctim_calib[25], pad_ctim_calib[24], 6'b0, pad_ctim_calib[23:0]};
  assign ref_tick    = ref_sync[1] & ~ref_sync[2];
  assign unused_bits = ^{tcipif_coretim_addr[15:8], tcipif_coretim_addr[1:0], tcipif_coretim_wdata};

  assign coretim_tcipif_cmplt = tcipif_coretim_sel;
  assign ctim_pad_int_any     = |ctim_pad_int_vld;

  // Three-flop synchroniser for the reference clock; ff2 & ~ff3 marks a rising edge
  always_ff @(posedge ct_reg_cpuclk or negedge coretim_rst_b) begin
    if (!coretim_rst_b) ref_sync <= 3'b000;
    else                ref_sync <= {ref_sync[1:0], pad_ctim_refclk};
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    logic                 en, tickint, clksrc, oneshot, cntflg;
    logic [PSC_WIDTH-1:0] psc, pc;
    logic [CNT_WIDTH-1:0] cnt, rvr;
    logic                 ch_hit, csr_wr, rvr_wr, cvr_wr, csr_rd;
    logic                 clksrc_eff, src_tick, active, step, reach_zero;
    logic [31:0]          csr_val;

    assign ch_hit     = (addr_ch == 4'(g + 1));
    assign csr_wr     = wr_en & ch_hit & (addr_reg == 2'b00);
    assign rvr_wr     = wr_en & ch_hit & (addr_reg == 2'b01);
    assign cvr_wr     = wr_en & ch_hit & (addr_reg == 2'b10);
    assign csr_rd     = rd_en & ch_hit & (addr_reg == 2'b00);
    assign clksrc_eff = noref | clksrc;
    assign active     = en & ~core_dbgon;

`ifdef CR_CORETIM_CASCADE_EN
    logic casc, rz_q, casc_tick;
    if (g == 0) begin : g_casc_head
      assign casc_tick = 1'b0;
    end else begin : g_casc_link
      assign casc_tick = rz_q_vec[g-1];
    end
    assign src_tick    = casc ? casc_tick : (clksrc_eff | ref_tick);
    assign rz_q_vec[g] = rz_q;

    // Cascade enable (never set on channel 0) and one-cycle-delayed reach-zero for the next channel
    always_ff @(posedge ct_reg_cpuclk or negedge coretim_rst_b) begin
      if (!coretim_rst_b) begin
        casc <= 1'b0;
        rz_q <= 1'b0;
      end else begin
        rz_q <= reach_zero;
        if (csr_wr && (g != 0)) casc <= tcipif_coretim_wdata[4];
      end
    end
`else
    assign src_tick = clksrc_eff | ref_tick;
`endif

    // A counter step happens when the prescaler wraps; a CVR write in the same cycle cancels the reach-zero
    assign step       = active & src_tick & (pc == psc);
    assign reach_zero = step & (cnt == CNT_WIDTH'(1)) & ~cvr_wr;

    // Prescaler and down-counter; CVR write clears both, debug or disable freezes both
    always_ff @(posedge ct_reg_cpuclk or negedge coretim_rst_b) begin
      if (!coretim_rst_b) begin
        cnt <= '0;
        pc  <= '0;
      end else if (cvr_wr) begin
        cnt <= '0;
        pc  <= '0;
      end else if (active && src_tick) begin
        if (pc == psc) begin
          pc <= '0;
          if (cnt == '0) begin
            if (rvr != '0) cnt <= rvr;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end else begin
          pc <= pc + 1'b1;
        end
      end
    end

    // Control fields and reload value; a CSR write overrides the one-shot auto-disable
    always_ff @(posedge ct_reg_cpuclk or negedge coretim_rst_b) begin
      if (!coretim_rst_b) begin
        en      <= 1'b0;
        tickint <= 1'b0;
        clksrc  <= 1'b1;
        oneshot <= 1'b0;
        psc     <= '0;
        rvr     <= '0;
      end else begin
        if (csr_wr) begin
          en      <= tcipif_coretim_wdata[0];
          tickint <= tcipif_coretim_wdata[1];
          oneshot <= tcipif_coretim_wdata[3];
          psc     <= tcipif_coretim_wdata[8 +: PSC_WIDTH];
          if (!noref) clksrc <= tcipif_coretim_wdata[2];
        end else if (reach_zero && oneshot) begin
          en <= 1'b0;
        end
        if (rvr_wr) rvr <= tcipif_coretim_wdata[CNT_WIDTH-1:0];
      end
    end

    // Count flag: CVR write clears, reach-zero sets, CSR read clears, in that priority
    always_ff @(posedge ct_reg_cpuclk or negedge coretim_rst_b) begin
      if (!coretim_rst_b)  cntflg <= 1'b0;
      else if (cvr_wr)     cntflg <= 1'b0;
      else if (reach_zero) cntflg <= 1'b1;
      else if (csr_rd)     cntflg <= 1'b0;
    end

    // Assemble the CSR read-back word with unused bits forced to zero
    always_comb begin
      csr_val                   = '0;
      csr_val[0]                = en;
      csr_val[1]                = tickint;
      csr_val[2]                = clksrc_eff;
      csr_val[3]                = oneshot;
`ifdef CR_CORETIM_CASCADE_EN
      csr_val[4]                = casc;
`endif
      csr_val[8 +: PSC_WIDTH]   = psc;
      csr_val[16]               = cntflg;
    end

    assign csr_word[g]         = csr_val;
    assign rvr_word[g]         = rvr;
    assign cnt_word[g]         = cnt;
    assign ctim_pad_int_vld[g] = tickint & cntflg;
  end

  // Read data mux; returns zero when idle, writing, or addressing an absent channel
  always_comb begin
    coretim_tcipif_rdata = '0;
    if (rd_en) begin
      for (int n = 0; n < CH_NUM; n++) begin
        if (addr_ch == 4'(n + 1)) begin
          case (addr_reg)
            2'b00:   coretim_tcipif_rdata = csr_word[n];
            2'b01:   coretim_tcipif_rdata = 32'(rvr_word[n]);
            2'b10:   coretim_tcipif_rdata = 32'(cnt_word[n]);
            default: coretim_tcipif_rdata = calib_word;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_cr_coretim_mch.sv
// tb_cr_coretim_mch: directed scoreboard bench for cr_coretim_mch.
// Stimulus pushes the expected read data and interrupt lines into a queue; a
// negedge monitor pops and compares whenever the DUT completes a read.
module tb_cr_coretim_mch;

  localparam int CH = 2;

  logic          ct_reg_cpuclk = 1'b0;
  logic          coretim_rst_b = 1'b0;
  logic          core_dbgon = 1'b0;
  logic          pad_ctim_refclk = 1'b0;
  logic [25:0]   pad_ctim_calib = 26'h1ABCDEF;
  logic          tcipif_coretim_sel = 1'b0;
  logic          tcipif_coretim_write = 1'b0;
  logic [15:0]   tcipif_coretim_addr = '0;
  logic [31:0]   tcipif_coretim_wdata = '0;
  logic          coretim_tcipif_cmplt;
  logic [31:0]   coretim_tcipif_rdata;
  logic [CH-1:0] ctim_pad_int_vld;
  logic          ctim_pad_int_any;

  typedef struct {
    string         name;
    logic [31:0]   rdata;
    logic [CH-1:0] intv;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fails  = 0;

  cr_coretim_mch #(.CNT_WIDTH(24), .CH_NUM(CH), .PSC_WIDTH(8)) dut (
    .ct_reg_cpuclk        (ct_reg_cpuclk),
    .coretim_rst_b        (coretim_rst_b),
    .core_dbgon           (core_dbgon),
    .pad_ctim_refclk      (pad_ctim_refclk),
    .pad_ctim_calib       (pad_ctim_calib),
    .tcipif_coretim_sel   (tcipif_coretim_sel),
    .tcipif_coretim_write (tcipif_coretim_write),
    .tcipif_coretim_addr  (tcipif_coretim_addr),
    .tcipif_coretim_wdata (tcipif_coretim_wdata),
    .coretim_tcipif_cmplt (coretim_tcipif_cmplt),
    .coretim_tcipif_rdata (coretim_tcipif_rdata),
    .ctim_pad_int_vld     (ctim_pad_int_vld),
    .ctim_pad_int_any     (ctim_pad_int_any)
  );

  always #5 ct_reg_cpuclk = ~ct_reg_cpuclk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // One bus cycle, driven just after a rising edge; reads queue their expectation
  task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                               input logic [31:0] exp_rd, input logic [CH-1:0] exp_int,
                               input string name);
    exp_t e;
    tcipif_coretim_sel   = 1'b1;
    tcipif_coretim_write = wr;
    tcipif_coretim_addr  = addr;
    tcipif_coretim_wdata = data;
    if (!wr) begin
      e.name  = name;
      e.rdata = exp_rd;
      e.intv  = exp_int;
      exp_q.push_back(e);
    end
    @(posedge ct_reg_cpuclk);
    #1;
    tcipif_coretim_sel   = 1'b0;
    tcipif_coretim_write = 1'b0;
  endtask

  task automatic bus_wr(input logic [15:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, addr, data, 32'h0, '0, "wr");
  endtask

  task automatic bus_rd(input logic [15:0] addr, input logic [31:0] exp_rd,
                        input logic [CH-1:0] exp_int, input string name);
    applyStimulus(1'b0, addr, 32'h0, exp_rd, exp_int, name);
  endtask

  // Monitor: every completed read is compared against the head of the scoreboard
  always @(negedge ct_reg_cpuclk) begin
    if (coretim_tcipif_cmplt === 1'b1 && tcipif_coretim_write === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL unexpected_read: actual=0x%08h required=none", coretim_tcipif_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput({mon_e.name, " rdata"}, coretim_tcipif_rdata, mon_e.rdata);
        checkOutput({mon_e.name, " int_vld"}, 32'(ctim_pad_int_vld), 32'(mon_e.intv));
        checkOutput({mon_e.name, " int_any"}, 32'(ctim_pad_int_any), 32'(|mon_e.intv));
      end
    end
  end

  initial begin
    logic [31:0] exp_cnt;
    repeat (3) @(posedge ct_reg_cpuclk);
    #1;
    coretim_rst_b = 1'b1;

    $display("[TB] reset values, calib, unmapped addresses");
    bus_rd(16'h0010, 32'h0000_0004, 2'b00, "rst_csr0");
    bus_rd(16'h001C, 32'h40AB_CDEF, 2'b00, "calib");
    bus_rd(16'h0020, 32'h0000_0004, 2'b00, "rst_csr1");
    bus_rd(16'h000C, 32'h0000_0000, 2'b00, "unmapped_ch0");
    bus_wr(16'h0030, 32'h0000_0007);
    bus_wr(16'h0000, 32'h0000_0007);
    bus_rd(16'h0010, 32'h0000_0004, 2'b00, "csr0_after_bad_wr");
    bus_rd(16'h0020, 32'h0000_0004, 2'b00, "csr1_after_bad_wr");
    bus_rd(16'h0030, 32'h0000_0000, 2'b00, "unmapped_ch3");
    bus_rd(16'h0014, 32'h0000_0000, 2'b00, "rst_rvr0");

    $display("[TB] ch0 periodic on cpuclk");
    bus_wr(16'h0014, 32'd3);
    bus_wr(16'h0018, 32'd0);
    bus_wr(16'h0010, 32'h0000_0007);
    bus_rd(16'h0018, 32'd0, 2'b00, "per_c0");
    bus_rd(16'h0018, 32'd3, 2'b00, "per_c1");
    bus_rd(16'h0018, 32'd2, 2'b00, "per_c2");
    bus_rd(16'h0018, 32'd1, 2'b00, "per_c3");
    bus_rd(16'h0018, 32'd0, 2'b01, "per_c4");
    bus_rd(16'h0018, 32'd3, 2'b01, "per_c5");
    bus_rd(16'h0010, 32'h0001_0007, 2'b01, "per_csr_flag");
    bus_rd(16'h0018, 32'd1, 2'b00, "per_c7_cleared");
    bus_rd(16'h0018, 32'd0, 2'b01, "per_c8");
    bus_wr(16'h0010, 32'h0000_0000);
    bus_rd(16'h0018, 32'd2, 2'b00, "per_dis_hold_a");
    bus_rd(16'h0018, 32'd2, 2'b00, "per_dis_hold_b");
    bus_wr(16'h0018, 32'd0);
    bus_rd(16'h0010, 32'h0000_0000, 2'b00, "per_csr_final");

    $display("[TB] ch1 one-shot");
    bus_wr(16'h0024, 32'd5);
    bus_wr(16'h0028, 32'd0);
    bus_wr(16'h0020, 32'h0000_000F);
    bus_rd(16'h0028, 32'd0, 2'b00, "os_c0");
    bus_rd(16'h0028, 32'd5, 2'b00, "os_c1");
    bus_rd(16'h0028, 32'd4, 2'b00, "os_c2");
    bus_rd(16'h0028, 32'd3, 2'b00, "os_c3");
    bus_rd(16'h0028, 32'd2, 2'b00, "os_c4");
    bus_rd(16'h0028, 32'd1, 2'b00, "os_c5");
    bus_rd(16'h0028, 32'd0, 2'b10, "os_c6");
    bus_rd(16'h0028, 32'd0, 2'b10, "os_hold");
    bus_rd(16'h0020, 32'h0001_000E, 2'b10, "os_csr_flag");
    bus_rd(16'h0020, 32'h0000_000E, 2'b00, "os_csr_clear");
    bus_rd(16'h0010, 32'h0000_0000, 2'b00, "os_ch0_csr");
    bus_rd(16'h0014, 32'd3, 2'b00, "os_ch0_rvr");
    bus_rd(16'h0018, 32'd0, 2'b00, "os_ch0_cvr");

    $display("[TB] ch0 prescaler and debug freeze");
    bus_wr(16'h0014, 32'd2);
    bus_wr(16'h0018, 32'd0);
    bus_wr(16'h0010, 32'h0000_0305);
    for (int i = 0; i < 9; i++) begin
      exp_cnt = (i < 4) ? 32'd0 : (i < 8) ? 32'd2 : 32'd1;
      bus_rd(16'h0018, exp_cnt, 2'b00, $sformatf("psc_c%0d", i));
    end
    core_dbgon = 1'b1;
    for (int i = 0; i < 10; i++) bus_rd(16'h0018, 32'd1, 2'b00, $sformatf("dbg_c%0d", i));
    core_dbgon = 1'b0;
    bus_rd(16'h0018, 32'd1, 2'b00, "resume_a");
    bus_rd(16'h0018, 32'd1, 2'b00, "resume_b");
    bus_rd(16'h0018, 32'd1, 2'b00, "resume_c");
    bus_rd(16'h0018, 32'd0, 2'b00, "resume_zero");
    bus_rd(16'h0010, 32'h0001_0305, 2'b00, "psc_csr");
    bus_wr(16'h0010, 32'h0000_0004);
    bus_wr(16'h0018, 32'd0);

    $display("[TB] ch0 reference clock source and noref");
    bus_wr(16'h0014, 32'd10);
    bus_wr(16'h0018, 32'd0);
    bus_wr(16'h0010, 32'h0000_0001);
    for (int i = 0; i < 20; i++) begin
      pad_ctim_refclk = ((i % 8) < 4);
      exp_cnt = (i < 3) ? 32'd0 : (i < 11) ? 32'd10 : (i < 19) ? 32'd9 : 32'd8;
      bus_rd(16'h0018, exp_cnt, 2'b00, $sformatf("ref_c%0d", i));
    end
    pad_ctim_refclk = 1'b0;
    bus_wr(16'h0010, 32'h0000_0000);
    pad_ctim_calib = 26'h2ABCDEF;
    bus_rd(16'h0010, 32'h0000_0004, 2'b00, "noref_csr");
    bus_rd(16'h001C, 32'h80AB_CDEF, 2'b00, "noref_calib");
    bus_wr(16'h0010, 32'h0000_0001);
    bus_rd(16'h0010, 32'h0000_0005, 2'b00, "noref_csr_en");
    bus_rd(16'h0018, 32'd7, 2'b00, "noref_cnt_a");
    bus_rd(16'h0018, 32'd6, 2'b00, "noref_cnt_b");
    bus_wr(16'h0010, 32'h0000_0000);
    pad_ctim_calib = 26'h1ABCDEF;
    bus_wr(16'h0018, 32'd0);

    $display("[TB] cntflg collisions");
    bus_wr(16'h0014, 32'd2);
    bus_wr(16'h0018, 32'd0);
    bus_wr(16'h0010, 32'h0000_0007);
    bus_rd(16'h0018, 32'd0, 2'b00, "col_c0");
    bus_rd(16'h0018, 32'd2, 2'b00, "col_c1");
    bus_wr(16'h0018, 32'd0);
    bus_rd(16'h0010, 32'h0000_0007, 2'b00, "col_cvr_wins");
    bus_rd(16'h0018, 32'd2, 2'b00, "col_c4");
    bus_rd(16'h0010, 32'h0000_0007, 2'b00, "col_read_old");
    bus_rd(16'h0018, 32'd0, 2'b01, "col_flag_set");
    bus_rd(16'h0010, 32'h0001_0007, 2'b01, "col_csr_flag");
    bus_rd(16'h0018, 32'd1, 2'b00, "col_c8");

    $display("[TB] reset mid-count");
    coretim_rst_b = 1'b0;
    bus_rd(16'h0010, 32'h0000_0004, 2'b00, "midrst_csr0");
    bus_rd(16'h0020, 32'h0000_0004, 2'b00, "midrst_csr1");
    bus_rd(16'h0018, 32'd0, 2'b00, "midrst_cvr0");
    coretim_rst_b = 1'b1;
    bus_rd(16'h0014, 32'd0, 2'b00, "midrst_rvr0");

    repeat (2) @(posedge ct_reg_cpuclk);
    #1;
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
